// File: rtl/dwconv_pkg.sv
// Shared definitions for the depthwise conv operand sequencer.
//   seq_state_t : LOAD (buffer weights + frame) / EMIT (replay operand pairs)
//   out_w()     : output width for a square input, square kernel, no padding
//   addr_w()    : counter/address width for a given depth (at least 1 bit)
package dwconv_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } seq_state_t;

  function automatic int unsigned out_w(input int unsigned img_w,
                                        input int unsigned k,
                                        input int unsigned stride);
    return (img_w - k) / stride + 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dwconv_window_counter.sv
// Nested window/tap counter for the operand sequencer.
// Order, outer to inner: oy, ox, ky, kx. oy/ox wrap at OUT_W, ky/kx at K.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears all counts)
//   advance         : step to the next tap
//   oy, ox, ky, kx  : current indices
//   tap_last        : current tap is ky=kx=K-1
//   frame_last      : current tap is the last tap of the last window
module dwconv_window_counter
  import dwconv_pkg::*;
#(
  parameter  int unsigned OUT_W = 6,
  parameter  int unsigned K     = 3,
  localparam int unsigned OW    = addr_w(OUT_W),
  localparam int unsigned KW    = addr_w(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [OW-1:0] oy,
  output logic [OW-1:0] ox,
  output logic [KW-1:0] ky,
  output logic [KW-1:0] kx,
  output logic          tap_last,
  output logic          frame_last
);

  logic kx_wrap, ky_wrap, ox_wrap, oy_wrap;

  assign kx_wrap    = (kx == KW'(K - 1));
  assign ky_wrap    = (ky == KW'(K - 1));
  assign ox_wrap    = (ox == OW'(OUT_W - 1));
  assign oy_wrap    = (oy == OW'(OUT_W - 1));
  assign tap_last   = kx_wrap && ky_wrap;
  assign frame_last = tap_last && ox_wrap && oy_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else if (advance) begin
      if (kx_wrap) begin
        kx <= '0;
        if (ky_wrap) begin
          ky <= '0;
          if (ox_wrap) begin
            ox <= '0;
            oy <= oy_wrap ? '0 : oy + 1'b1;
          end else begin
            ox <= ox + 1'b1;
          end
        end else begin
          ky <= ky + 1'b1;
        end
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dwconv2d_operand_sequencer.sv
// Transmit-side feeder for the depthwise 2D conv operator.
// Buffers one KxK weight set and one IMG_W x IMG_W frame, then replays them
// as (pixel, weight) operand pairs in window order, one pair per beat.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   w_valid/w_ready/w_data   : weight stream, raster order ky*K+kx
//   s_valid/s_ready/s_data   : pixel stream, raster order y*IMG_W+x
//   m_valid/m_ready          : operand pair handshake towards the conv
//   m_input_data             : pixel operand
//   m_weight_data            : weight operand
//   m_tap_last               : last tap of the current window
//   m_frame_last             : last tap of the last window of the frame
//   busy                     : high while emitting
module dwconv2d_operand_sequencer
  import dwconv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_input_data,
  output logic [DATA_W-1:0] m_weight_data,
  output logic              m_tap_last,
  output logic              m_frame_last,
  output logic              busy
);

  localparam int unsigned OUT_W = out_w(IMG_W, K, STRIDE);
  localparam int unsigned NPIX  = IMG_W * IMG_W;
  localparam int unsigned NWGT  = K * K;
  localparam int unsigned PA_W  = addr_w(NPIX);
  localparam int unsigned WA_W  = addr_w(NWGT);
  localparam int unsigned OW    = addr_w(OUT_W);
  localparam int unsigned KW    = addr_w(K);

  seq_state_t        state;
  logic [DATA_W-1:0] pix_mem [NPIX];
  logic [DATA_W-1:0] wgt_mem [NWGT];
  logic [PA_W-1:0]   pix_cnt;
  logic [WA_W-1:0]   wgt_cnt;
  logic [OW-1:0]     oy, ox;
  logic [KW-1:0]     ky, kx;
  logic              tap_last, frame_last;
  logic              w_fire, s_fire, load_pair, frame_done;
  logic [PA_W-1:0]   pix_addr;
  logic [WA_W-1:0]   wgt_addr;

  // The readies are only ever high in LOAD, so a fire implies LOAD.
  assign w_fire = w_valid && w_ready;
  assign s_fire = s_valid && s_ready;

  // Refill the output registers when empty or when the held pair is taken,
  // except after the frame's last pair has been issued.
  assign load_pair  = (state == EMIT) && (!m_valid || (m_ready && !m_frame_last));
  assign frame_done = m_valid && m_ready && m_frame_last;

  assign pix_addr = (PA_W'(oy) * PA_W'(STRIDE) + PA_W'(ky)) * PA_W'(IMG_W)
                  + PA_W'(ox) * PA_W'(STRIDE) + PA_W'(kx);
  assign wgt_addr = WA_W'(ky) * WA_W'(K) + WA_W'(kx);

  assign busy = (state == EMIT);

  dwconv_window_counter #(
    .OUT_W (OUT_W),
    .K     (K)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .advance    (load_pair),
    .oy         (oy),
    .ox         (ox),
    .ky         (ky),
    .kx         (kx),
    .tap_last   (tap_last),
    .frame_last (frame_last)
  );

  always_ff @(posedge clk) begin
    if (w_fire) wgt_mem[wgt_cnt] <= w_data;
    if (s_fire) pix_mem[pix_cnt] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      w_ready       <= 1'b1;
      s_ready       <= 1'b1;
      wgt_cnt       <= '0;
      pix_cnt       <= '0;
      m_valid       <= 1'b0;
      m_tap_last    <= 1'b0;
      m_frame_last  <= 1'b0;
      m_input_data  <= '0;
      m_weight_data <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (w_fire) begin
            if (wgt_cnt == WA_W'(NWGT - 1)) w_ready <= 1'b0;
            wgt_cnt <= wgt_cnt + 1'b1;
          end
          if (s_fire) begin
            if (pix_cnt == PA_W'(NPIX - 1)) s_ready <= 1'b0;
            pix_cnt <= pix_cnt + 1'b1;
          end
          // Both readies low means both buffers are full.
          if (!w_ready && !s_ready) begin
            state   <= EMIT;
            wgt_cnt <= '0;
            pix_cnt <= '0;
          end
        end
        EMIT: begin
          if (load_pair) begin
            m_valid       <= 1'b1;
            m_input_data  <= pix_mem[pix_addr];
            m_weight_data <= wgt_mem[wgt_addr];
            m_tap_last    <= tap_last;
            m_frame_last  <= frame_last;
          end else if (frame_done) begin
            m_valid      <= 1'b0;
            m_tap_last   <= 1'b0;
            m_frame_last <= 1'b0;
            state        <= LOAD;
            w_ready      <= 1'b1;
            s_ready      <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dwconv2d_operand_sequencer.sv
// Directed bench for dwconv2d_operand_sequencer.
// Instance a: IMG_W=4, K=3, STRIDE=1. Instance b: IMG_W=5, K=3, STRIDE=2.
// Both share stimulus; sel picks which instance's outputs are observed.
module tb_dwconv2d_operand_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  logic        w_valid, s_valid, m_ready;
  logic [31:0] w_data, s_data;

  logic        a_w_ready, a_s_ready, a_m_valid, a_tl, a_fl, a_busy;
  logic [31:0] a_pix, a_wgt;
  logic        b_w_ready, b_s_ready, b_m_valid, b_tl, b_fl, b_busy;
  logic [31:0] b_pix, b_wgt;

  logic        o_w_ready, o_s_ready, o_m_valid, o_tl, o_fl, o_busy;
  logic [31:0] o_pix, o_wgt;

  logic [31:0] cap_p[$];
  logic [31:0] cap_w[$];
  bit          cap_tl[$];
  bit          cap_fl[$];

  dwconv2d_operand_sequencer #(.DATA_W(32), .IMG_W(4), .K(3), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(a_w_ready), .w_data(w_data),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .m_valid(a_m_valid), .m_ready(m_ready),
    .m_input_data(a_pix), .m_weight_data(a_wgt),
    .m_tap_last(a_tl), .m_frame_last(a_fl), .busy(a_busy)
  );

  dwconv2d_operand_sequencer #(.DATA_W(32), .IMG_W(5), .K(3), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(b_w_ready), .w_data(w_data),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .m_valid(b_m_valid), .m_ready(m_ready),
    .m_input_data(b_pix), .m_weight_data(b_wgt),
    .m_tap_last(b_tl), .m_frame_last(b_fl), .busy(b_busy)
  );

  always_comb begin
    o_w_ready = sel ? b_w_ready : a_w_ready;
    o_s_ready = sel ? b_s_ready : a_s_ready;
    o_m_valid = sel ? b_m_valid : a_m_valid;
    o_tl      = sel ? b_tl      : a_tl;
    o_fl      = sel ? b_fl      : a_fl;
    o_busy    = sel ? b_busy    : a_busy;
    o_pix     = sel ? b_pix     : a_pix;
    o_wgt     = sel ? b_wgt     : a_wgt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m_valid"}, o_m_valid, 0);
    check({tag, "_busy"},    o_busy,    0);
    check({tag, "_w_ready"}, o_w_ready, 1);
    check({tag, "_s_ready"}, o_s_ready, 1);
  endtask

  // Loads pixels base+i and weights 100+j. seq=1 sends weights only after
  // every pixel has been accepted.
  task automatic load_frame(input int base, input bit seq);
    int  npix;
    int  si = 0;
    int  wi = 0;
    int  guard = 0;
    bit  saw_valid = 0;
    npix = sel ? 25 : 16;
    while ((si < npix || wi < 9) && guard < 300) begin
      @(negedge clk);
      guard++;
      if (o_m_valid) saw_valid = 1;
      if (seq && si == npix && wi == 0) begin
        check("seq_s_ready_low", o_s_ready, 0);
        check("seq_w_ready_high", o_w_ready, 1);
      end
      s_valid = (si < npix);
      s_data  = base + si;
      w_valid = (wi < 9) && (!seq || si >= npix);
      w_data  = 100 + wi;
      if (s_valid && o_s_ready) si++;
      if (w_valid && o_w_ready) wi++;
    end
    @(negedge clk);
    s_valid = 0;
    w_valid = 0;
    if (o_m_valid) saw_valid = 1;
    check("load_in_budget", guard < 300, 1);
    check("no_valid_during_load", saw_valid, 0);
  endtask

  // Collects beats. stall_at: beat number held off for 3 cycles (0 = none).
  // rst_at: beat number on which rst is raised (0 = none).
  task automatic run_frame(input int stall_at, input int rst_at, output int span);
    int          cyc = 0;
    int          stall = 0;
    int          first = -1;
    int          last = -1;
    bit          done = 0;
    logic [31:0] hp = '0;
    logic [31:0] hw = '0;
    cap_p.delete(); cap_w.delete(); cap_tl.delete(); cap_fl.delete();
    // Junk offered throughout EMIT must never be stored.
    s_valid = 1; s_data = 32'hDEAD;
    w_valid = 1; w_data = 32'hBEEF;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      m_ready = 1;
      if (o_m_valid) begin
        if (cap_p.size() + 1 == stall_at && stall < 3) begin
          if (stall == 0) begin
            hp = o_pix;
            hw = o_wgt;
          end else begin
            check("stall_pix_hold", o_pix, hp);
            check("stall_wgt_hold", o_wgt, hw);
          end
          m_ready = 0;
          stall++;
        end else begin
          if (first < 0) begin
            first = cyc;
            check("busy_in_emit", o_busy, 1);
          end
          if (stall == 3 && cap_p.size() + 1 == stall_at)
            check("stall_release_pix", o_pix, hp);
          last = cyc;
          cap_p.push_back(o_pix);
          cap_w.push_back(o_wgt);
          cap_tl.push_back(o_tl);
          cap_fl.push_back(o_fl);
          if (o_fl || cap_p.size() == rst_at) begin
            done = 1;
            s_valid = 0;
            w_valid = 0;
          end
          if (cap_p.size() == rst_at) rst = 1;
        end
      end
    end
    check("frame_in_budget", done, 1);
    span = last - first + 1;
  endtask

  task automatic verify(input int base, input int imgw, input int stride,
                        input int n_cnt, input int total);
    int outw, kx, ky, ox, oy;
    outw = (imgw - 3) / stride + 1;
    check("beat_count", cap_p.size(), n_cnt);
    for (int n = 0; n < n_cnt && n < cap_p.size(); n++) begin
      kx = n % 3;
      ky = (n / 3) % 3;
      ox = (n / 9) % outw;
      oy = n / (9 * outw);
      check($sformatf("pix[%0d]", n), cap_p[n], base + (oy * stride + ky) * imgw + ox * stride + kx);
      check($sformatf("wgt[%0d]", n), cap_w[n], 100 + ky * 3 + kx);
      check($sformatf("tap_last[%0d]", n), cap_tl[n], (kx == 2 && ky == 2));
      check($sformatf("frame_last[%0d]", n), cap_fl[n], (n == total - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int span;
    w_valid = 0; s_valid = 0; w_data = '0; s_data = '0; m_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_m_valid", o_m_valid, 0);
    check("rst_tap_last", o_tl, 0);
    check("rst_frame_last", o_fl, 0);
    check("rst_pix", o_pix, 0);
    check("rst_wgt", o_wgt, 0);
    check_idle("rst");
    rst = 0;

    // Basic window order, concurrent load.
    load_frame(0, 0);
    run_frame(0, 0, span);
    check("basic_span", span, 36);
    verify(0, 4, 1, 36, 36);
    if (cap_p.size() == 36) begin
      check("beat1_pix", cap_p[0], 0);
      check("beat1_wgt", cap_w[0], 100);
      check("beat9_pix", cap_p[8], 10);
      check("beat9_wgt", cap_w[8], 108);
      check("beat9_tap_last", cap_tl[8], 1);
      check("beat10_pix", cap_p[9], 1);
      check("beat10_wgt", cap_w[9], 100);
      check("beat36_pix", cap_p[35], 15);
      check("beat36_wgt", cap_w[35], 108);
      check("beat36_frame_last", cap_fl[35], 1);
    end
    @(negedge clk);
    check_idle("after_frame1");

    // Back-to-back second frame.
    load_frame(200, 0);
    run_frame(0, 0, span);
    check("frame2_span", span, 36);
    verify(200, 4, 1, 36, 36);
    @(negedge clk);
    check_idle("after_frame2");

    // Backpressure at beat 5.
    load_frame(0, 0);
    run_frame(5, 0, span);
    check("stall_span", span, 39);
    verify(0, 4, 1, 36, 36);
    @(negedge clk);
    check_idle("after_stall");

    // Weights only after all pixels.
    load_frame(0, 1);
    run_frame(0, 0, span);
    verify(0, 4, 1, 36, 36);
    @(negedge clk);
    check_idle("after_seq");

    // Reset on beat 20, then a fresh frame.
    load_frame(0, 0);
    run_frame(0, 20, span);
    verify(0, 4, 1, 20, 36);
    @(negedge clk);
    rst = 0;
    check_idle("after_rst");
    check("after_rst_pix", o_pix, 0);
    load_frame(50, 0);
    run_frame(0, 0, span);
    verify(50, 4, 1, 36, 36);
    if (cap_p.size() > 0) check("fresh_first_pix", cap_p[0], 50);
    @(negedge clk);

    // Stride 2 on the 5x5 instance.
    rst = 1;
    sel = 1;
    @(negedge clk);
    rst = 0;
    check_idle("b_rst");
    load_frame(0, 0);
    run_frame(0, 0, span);
    check("b_span", span, 36);
    verify(0, 5, 2, 36, 36);
    if (cap_p.size() == 36) begin
      check("b_win01_pix", cap_p[9], 2);
      check("b_win10_pix", cap_p[18], 10);
      check("b_last_pix", cap_p[35], 24);
    end
    @(negedge clk);
    check_idle("b_after_frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dwconv2d_operand_sequencer.md
Name: dwconv2d_operand_sequencer

Overview:
- Transmit-side feeder for the depthwise 2D conv operator (square input, square kernel).
- Buffers one channel's KxK weight set and one IMG_W x IMG_W input frame.
- Replays them as a serial stream of (pixel, weight) operand pairs, one pair per beat, in window order.
- Drives the conv's valid/input_data/weight_data port; output side has a ready for backpressure, which the consumer may tie high.

Parameters:
- DATA_W, 32, width of pixel and weight words.
- IMG_W, 8, input height and width (square), >= K.
- K, 3, kernel height and width (square), >= 1.
- STRIDE, 1, convolution stride, >= 1. (IMG_W-K) must be divisible by STRIDE.
- Derived: OUT_W = (IMG_W-K)/STRIDE+1; no padding (PAD=0 fixed).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- w_valid  in  1  weight word valid.
- w_ready  out  1  weight word accepted when w_valid&w_ready.
- w_data  in  DATA_W  weight, raster order ky*K+kx.
- s_valid  in  1  pixel valid.
- s_ready  out  1  pixel accepted when s_valid&s_ready.
- s_data  in  DATA_W  pixel, raster order y*IMG_W+x.
- m_valid  out  1  operand pair valid (to conv valid_in).
- m_ready  in  1  consumer ready.
- m_input_data  out  DATA_W  pixel operand.
- m_weight_data  out  DATA_W  weight operand.
- m_tap_last  out  1  last tap (ky=kx=K-1) of the current window.
- m_frame_last  out  1  last tap of the last window of the frame.
- busy  out  1  high in EMIT.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - Reset values: m_valid=0, m_tap_last=0, m_frame_last=0, m_input_data=0, m_weight_data=0, busy=0, w_ready=1, s_ready=1.
  - State returns to LOAD; all counters cleared.
  - Memory contents are don't-care after reset.
  - Reset mid-EMIT aborts the frame: no further beats, and the partial frame is discarded.
- States: LOAD, EMIT.
- LOAD:
  - w_ready=1 until K*K weights are accepted; s_ready=1 until IMG_W*IMG_W pixels are accepted. The two streams load independently and concurrently.
  - Once both counts are complete, the next cycle enters EMIT; w_ready and s_ready drop to 0 on that transition.
- EMIT:
  - Nested counters, outer to inner: oy, ox, ky, kx, each wrapping (oy/ox at OUT_W, ky/kx at K).
  - Pixel address = (oy*STRIDE+ky)*IMG_W + ox*STRIDE+kx. Weight address = ky*K+kx.
  - Output registers (m_*) load the addressed pair. First m_valid is asserted 1 cycle after entering EMIT.
  - A beat transfers on m_valid&m_ready. On transfer the next pair loads in the same cycle, giving 1 beat/cycle when m_ready stays high.
  - While m_valid&!m_ready, all m_* outputs hold stable.
  - Total beats per frame = OUT_W*OUT_W*K*K.
- m_frame_last: after the beat with m_frame_last transfers, m_valid drops the next cycle and the state returns to LOAD with w_ready=s_ready=1.
  - Weights must be reloaded every frame; no weight-persist mode.
- Input handshakes with w_ready=0 or s_ready=0 are ignored (not stored).
- Widths:
  - Address counters sized by $clog2(IMG_W*IMG_W) and $clog2(K*K).
  - Index arithmetic is unsigned and computed at address width; no truncation for legal parameters.
- Storage: arrays with combinational read, written only in LOAD.

Decomposition:
- Shared package dwconv_pkg: state enum (LOAD, EMIT) and localparam helpers for OUT_W and address widths.
- One natural sub-module: dwconv_window_counter, the nested oy/ox/ky/kx counter with advance input and tap_last/frame_last outputs.

Test Plan:
- Basic window order: IMG_W=4, K=3, STRIDE=1; pixels p[i]=i, weights w[j]=100+j; m_ready=1.
  - Beat 1 -> (0,100).
  - Beat 9 -> (10,108), tap_last=1.
  - Beat 10 -> (1,100).
  - Beat 36 -> (15,108) with frame_last=1.
  - Exactly 36 beats, back-to-back.
- Stride: IMG_W=5, K=3, STRIDE=2, same data pattern.
  - Window (oy=0,ox=1) first beat -> pixel 2.
  - Window (1,0) first beat -> pixel 10.
  - Last beat -> pixel 24; 36 beats total.
- Backpressure: drop m_ready for 3 cycles at beat 5.
  - m_* held constant for those cycles.
  - Beat 5 still delivered exactly once; beat count and order unchanged.
- Load interleave: weights sent only after all 16 pixels (IMG_W=4).
  - No m_valid until the 9th weight is accepted.
  - s_ready=0 after pixel 16, while w_ready stays 1.
- Reset mid-EMIT: assert rst at beat 20 for 1 cycle.
  - Next cycle m_valid=0, busy=0, w_ready=s_ready=1.
  - A fresh load (p[i]=i+50) emits first beat pixel 50.
- Back-to-back frames: second frame loads after frame_last.
  - Only 1 idle cycle between the last beat and w_ready/s_ready=1.
  - Second frame's output matches the golden model.
